// File: rtl/pwl_tuner_pkg.sv
// Shared types, fixed-point scaling and code-to-value helpers for the PWL notch tuner.
// w0 is carried as integer rad/s, q in units of 0.01; slopes are per clk cycle (divide by TCLK for per-second).
package pwl_tuner_pkg;

  typedef enum logic [1:0] {IDLE, RAMP, SETTLE, DONE} tuner_state_t;

  localparam int unsigned W_WCODE    = 10;
  localparam int unsigned W_QCODE    = 6;
  localparam int unsigned W_W0       = 30;
  localparam int unsigned W_W0S      = 24;
  localparam int unsigned W_Q        = 9;
  localparam int unsigned W_QS       = 6;
  localparam int unsigned W0_MIN     = 6283200;
  localparam int unsigned W0_STEP    = 628320;
  localparam int unsigned MAX_DW     = 6283200;
  localparam int unsigned Q_MIN      = 50;
  localparam int unsigned Q_STEP     = 5;
  localparam int unsigned MAX_DQ     = 10;
  localparam int unsigned SETTLE_CYC = 16;
  localparam int unsigned W_CNT      = $clog2(SETTLE_CYC);

  function automatic logic [W_W0-1:0] w0_of_code(input logic [W_WCODE-1:0] c);
    return W_W0'(W0_MIN) + W_W0'(c) * W_W0'(W0_STEP);
  endfunction

  function automatic logic [W_Q-1:0] q_of_code(input logic [W_QCODE-1:0] c);
    return W_Q'(Q_MIN) + W_Q'(c) * W_Q'(Q_STEP);
  endfunction

endpackage

// File: rtl/pwl_slew_limiter.sv
// One slew-limited PWL channel: holds segment start value, slope and target.
// The position at an edge is start+slope; each step writes a new segment clamped to +/-MAX_STEP.
module pwl_slew_limiter #(
  parameter int unsigned W        = 30,
  parameter int unsigned WS       = 24,
  parameter int unsigned MAX_STEP = 1,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load,
  input  logic [W-1:0]  tgt_in,
  input  logic          step_en,
  output logic [W-1:0]  val,
  output logic [WS-1:0] slope,
  output logic [W-1:0]  cur_c,
  output logic          reached_c
);

  localparam logic signed [W:0] MAX_S = (W+1)'(MAX_STEP);

  logic [W-1:0]      val_q, val_d, tgt_q, tgt_d;
  logic [WS-1:0]     slope_q, slope_d;
  logic signed [W:0] cur_ext, diff;

  assign cur_ext   = $signed({1'b0, val_q}) + $signed({{(W+1-WS){slope_q[WS-1]}}, slope_q});
  assign diff      = $signed({1'b0, tgt_q}) - cur_ext;
  assign cur_c     = W'(cur_ext);
  assign reached_c = (diff == '0);

  // Clamp keeps the last segment landing exactly on target
  always_comb begin
    val_d   = val_q;
    slope_d = slope_q;
    tgt_d   = tgt_q;
    if (load) tgt_d = tgt_in;
    if (step_en) begin
      val_d = W'(cur_ext);
      if (diff > MAX_S)       slope_d = WS'(MAX_S);
      else if (diff < -MAX_S) slope_d = WS'(-MAX_S);
      else                    slope_d = WS'(diff);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      val_q   <= W'(RST_VAL);
      slope_q <= '0;
      tgt_q   <= W'(RST_VAL);
    end else begin
      val_q   <= val_d;
      slope_q <= slope_d;
      tgt_q   <= tgt_d;
    end
  end

  assign val   = val_q;
  assign slope = slope_q;

endmodule

// File: rtl/pwl_notch_tuner.sv
// Rate-limited w0/q controller for the PWL notch filter with req/ack capture and settle flag.
// Define NOTCH_TUNER_Q_RAMP_EN to slew q as well; otherwise q steps on the capture edge.
module pwl_notch_tuner
  import pwl_tuner_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               req,
  input  logic [W_WCODE-1:0] w0_code,
  input  logic [W_QCODE-1:0] q_code,
  output logic               ack,
  output logic               busy,
  output logic               done,
  output logic [W_W0-1:0]    w0,
  output logic [W_W0S-1:0]   w0_slope,
  output logic [W_Q-1:0]     q,
  output logic [W_QS-1:0]    q_slope
);

  tuner_state_t     state_q, state_d;
  logic [W_CNT-1:0] cnt_q, cnt_d;
  logic             ack_q, ack_d, busy_q, busy_d, done_q, done_d;
  logic             cap_c, step_c;
  logic [W_W0-1:0]  w0_cur_c;
  logic             w0_reached_c, q_match_c, q_reached_c;

  pwl_slew_limiter #(
    .W(W_W0), .WS(W_W0S), .MAX_STEP(MAX_DW), .RST_VAL(W0_MIN)
  ) u_w0 (
    .clk(clk), .rstn(rstn), .load(cap_c), .tgt_in(w0_of_code(w0_code)),
    .step_en(step_c), .val(w0), .slope(w0_slope), .cur_c(w0_cur_c),
    .reached_c(w0_reached_c)
  );

`ifdef NOTCH_TUNER_Q_RAMP_EN
  logic [W_Q-1:0] q_cur_c;

  pwl_slew_limiter #(
    .W(W_Q), .WS(W_QS), .MAX_STEP(MAX_DQ), .RST_VAL(Q_MIN)
  ) u_q (
    .clk(clk), .rstn(rstn), .load(cap_c), .tgt_in(q_of_code(q_code)),
    .step_en(step_c), .val(q), .slope(q_slope), .cur_c(q_cur_c),
    .reached_c(q_reached_c)
  );

  assign q_match_c = (q_cur_c == q_of_code(q_code));
`else
  logic [W_Q-1:0] q_q, q_d;

  // q jumps straight to target on capture, never ramps
  always_comb begin
    q_d = q_q;
    if (cap_c) q_d = q_of_code(q_code);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) q_q <= W_Q'(Q_MIN);
    else       q_q <= q_d;
  end

  assign q           = q_q;
  assign q_slope     = '0;
  assign q_match_c   = 1'b1;
  assign q_reached_c = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    cap_c   = 1'b0;
    step_c  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (req) begin
          cap_c  = 1'b1;
          ack_d  = 1'b1;
          busy_d = 1'b1;
          done_d = 1'b0;
          cnt_d  = '0;
          if (w0_cur_c == w0_of_code(w0_code) && q_match_c) state_d = SETTLE;
          else                                             state_d = RAMP;
        end
      end
      RAMP: begin
        step_c = 1'b1;
        if (w0_reached_c && q_reached_c) begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
      end
      SETTLE: begin
        if (cnt_q == W_CNT'(SETTLE_CYC - 1)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + W_CNT'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ack  = ack_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_pwl_notch_tuner.sv
// Directed bench for pwl_notch_tuner: ramp up/down, same-code settle, busy req hold, mid-ramp reset, q step/ramp.
// Values in fixed point: w0 rad/s, q in 0.01 units, slopes per clk cycle.
module tb_pwl_notch_tuner;

  logic        clk = 1'b0;
  logic        rstn, req;
  logic [9:0]  w0_code;
  logic [5:0]  q_code;
  logic        ack, busy, done;
  logic [29:0] w0;
  logic [23:0] w0_slope;
  logic [8:0]  q;
  logic [5:0]  q_slope;

  int n_cmp = 0;
  int n_err = 0;

  pwl_notch_tuner dut (
    .clk(clk), .rstn(rstn), .req(req), .w0_code(w0_code), .q_code(q_code),
    .ack(ack), .busy(busy), .done(done), .w0(w0), .w0_slope(w0_slope),
    .q(q), .q_slope(q_slope)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req = 1'b0; w0_code = '0; q_code = '0;
    #22;
    rstn = 1'b1;
    tick();
    n_cmp++; if (w0 !== 30'd6283200) begin n_err++; $display("FAIL reset_w0 got %0d want 6283200", w0); end
    n_cmp++; if (w0_slope !== 24'd0) begin n_err++; $display("FAIL reset_w0_slope got %0d want 0", w0_slope); end
    n_cmp++; if (q !== 9'd50) begin n_err++; $display("FAIL reset_q got %0d want 50", q); end
    n_cmp++; if ({ack, busy, done} !== 3'b000) begin n_err++; $display("FAIL reset_flags got %b want 000", {ack, busy, done}); end
  endtask

  task automatic test_ramp_up();
    w0_code = 10'd100; q_code = 6'd10; req = 1'b1;
    tick();
    req = 1'b0;
    n_cmp++; if ({ack, busy} !== 2'b11) begin n_err++; $display("FAIL up_ack got %b want 11", {ack, busy}); end
    n_cmp++; if (w0_slope !== 24'd0) begin n_err++; $display("FAIL up_cap_slope got %0d want 0", w0_slope); end
`ifdef NOTCH_TUNER_Q_RAMP_EN
    n_cmp++; if (q !== 9'd50) begin n_err++; $display("FAIL up_cap_q got %0d want 50", q); end
`else
    n_cmp++; if (q !== 9'd100) begin n_err++; $display("FAIL up_cap_q got %0d want 100", q); end
`endif
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_cmp++;
      if (w0 !== 30'(6283200 * k) || w0_slope !== 24'd6283200 || ack !== 1'b0) begin
        n_err++;
        $display("FAIL up_ramp_%0d got w0=%0d slope=%0d ack=%b want w0=%0d slope=6283200 ack=0",
                 k, w0, w0_slope, ack, 6283200 * k);
      end
    end
    tick();
    n_cmp++; if (w0 !== 30'd69115200 || w0_slope !== 24'd0) begin n_err++; $display("FAIL up_land got w0=%0d slope=%0d want 69115200/0", w0, w0_slope); end
    n_cmp++; if (q !== 9'd100 || q_slope !== 6'd0) begin n_err++; $display("FAIL up_q got q=%0d slope=%0d want 100/0", q, q_slope); end
    repeat (15) tick();
    n_cmp++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL up_settle15 got %b want 10", {busy, done}); end
    tick();
    n_cmp++; if ({busy, done} !== 2'b01) begin n_err++; $display("FAIL up_done got %b want 01", {busy, done}); end
  endtask

  task automatic test_ramp_down();
    w0_code = 10'd95; q_code = 6'd10; req = 1'b1;
    tick();
    req = 1'b0;
    n_cmp++; if ({ack, done} !== 2'b10) begin n_err++; $display("FAIL dn_ack got %b want 10", {ack, done}); end
    tick();
    n_cmp++; if (w0 !== 30'd69115200 || w0_slope !== 24'(-3141600)) begin n_err++; $display("FAIL dn_seg got w0=%0d slope=%0d want 69115200/-3141600", w0, $signed(w0_slope)); end
    tick();
    n_cmp++; if (w0 !== 30'd65973600 || w0_slope !== 24'd0) begin n_err++; $display("FAIL dn_land got w0=%0d slope=%0d want 65973600/0", w0, w0_slope); end
    repeat (16) tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL dn_done got %b want 1", done); end
  endtask

  task automatic test_same_code();
    logic moved = 1'b0;
    w0_code = 10'd95; q_code = 6'd10; req = 1'b1;
    tick();
    req = 1'b0;
    n_cmp++; if ({ack, busy, done} !== 3'b110) begin n_err++; $display("FAIL same_ack got %b want 110", {ack, busy, done}); end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (w0_slope !== 24'd0 || w0 !== 30'd65973600) moved = 1'b1;
    end
    n_cmp++; if (moved !== 1'b0) begin n_err++; $display("FAIL same_hold got moved=%b want 0", moved); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL same_early got done=%b want 0", done); end
    tick();
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL same_done got %b want 1", done); end
  endtask

  task automatic test_req_while_busy();
    int got = -1;
    w0_code = 10'd0; q_code = 6'd10; req = 1'b1;
    tick();
    n_cmp++; if (ack !== 1'b1) begin n_err++; $display("FAIL busy_first_ack got %b want 1", ack); end
    w0_code = 10'd50;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (ack === 1'b1) begin got = i; break; end
    end
    req = 1'b0;
    n_cmp++; if (got != 28) begin n_err++; $display("FAIL busy_ack_cycle got %0d want 28", got); end
    n_cmp++; if ({busy, done} !== 2'b10 || w0 !== 30'd6283200) begin n_err++; $display("FAIL busy_recap got bd=%b w0=%0d want 10/6283200", {busy, done}, w0); end
    tick();
    tick();
    n_cmp++; if (w0 !== 30'd12566400 || w0_slope !== 24'd6283200) begin n_err++; $display("FAIL busy_mid got w0=%0d slope=%0d want 12566400/6283200", w0, w0_slope); end
    #2 rstn = 1'b0;
    #1;
    n_cmp++; if (w0 !== 30'd6283200 || w0_slope !== 24'd0) begin n_err++; $display("FAIL midrst_w0 got w0=%0d slope=%0d want 6283200/0", w0, w0_slope); end
    n_cmp++; if ({ack, busy, done} !== 3'b000) begin n_err++; $display("FAIL midrst_flags got %b want 000", {ack, busy, done}); end
    #3 rstn = 1'b1;
    tick();
  endtask

  task automatic test_q_target();
    logic w0_moved = 1'b0;
    w0_code = 10'd0; q_code = 6'd20; req = 1'b1;
    tick();
    req = 1'b0;
    n_cmp++; if ({ack, busy} !== 2'b11) begin n_err++; $display("FAIL q_ack got %b want 11", {ack, busy}); end
`ifdef NOTCH_TUNER_Q_RAMP_EN
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (w0_slope !== 24'd0) w0_moved = 1'b1;
      n_cmp++;
      if (q !== 9'(50 + 10 * (k - 1)) || q_slope !== 6'd10) begin
        n_err++;
        $display("FAIL q_ramp_%0d got q=%0d slope=%0d want %0d/10", k, q, q_slope, 50 + 10 * (k - 1));
      end
    end
    tick();
    n_cmp++; if (q !== 9'd150 || q_slope !== 6'd0) begin n_err++; $display("FAIL q_land got q=%0d slope=%0d want 150/0", q, q_slope); end
`else
    n_cmp++; if (q !== 9'd150 || q_slope !== 6'd0) begin n_err++; $display("FAIL q_step got q=%0d slope=%0d want 150/0", q, q_slope); end
`endif
    for (int i = 0; i < 16; i++) begin
      tick();
      if (w0_slope !== 24'd0) w0_moved = 1'b1;
    end
    n_cmp++; if (w0_moved !== 1'b0 || w0 !== 30'd6283200) begin n_err++; $display("FAIL q_w0_hold got moved=%b w0=%0d want 0/6283200", w0_moved, w0); end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL q_done got %b want 1", done); end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_same_code();
    test_req_while_busy();
    test_q_target();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
